if_prefetch_unit: RTL and testbench

- Instruction-fetch stage with prefetch buffering. It sits directly upstream of the decode stage.
- Owns the program counter and issues word addresses to instruction memory over a req/ack handshake. It accepts in-order responses of variable latency and buffers them in a DEPTH-entry FIFO.
- Presents {IR, NPC} pairs to decode through a valid/ready handshake.
- Takes branch redirects from the execute stage. A redirect flushes both queued and in-flight fetches.

---
 rtl/if_prefetch_unit_if.sv | 38 +++
 rtl/if_prefetch_unit.sv | 181 ++++++++++++++++++
 tb/tb_if_prefetch_unit.sv | 389 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_prefetch_unit_if.sv
// Fetch-stage bundle: instruction-memory request/response, execute redirect,
// and the decode-side valid/ready channel.
interface if_prefetch_unit_if #(
  parameter int unsigned AW = 32
);
  // Instruction memory request / response
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic          imem_rvalid;
  logic [31:0]   imem_rdata;
  // Redirect from execute
  logic          br_en;
  logic [AW-1:0] br_target;
  // Decode channel
  logic          id_valid;
  logic          id_ready;
  logic [31:0]   id_ir;
  logic [AW-1:0] id_npc;

  // Fetch unit side
  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rvalid, imem_rdata,
    input  br_en, br_target,
    output id_valid, id_ir, id_npc,
    input  id_ready
  );

  // Memory / execute / decode side
  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rvalid, imem_rdata,
    output br_en, br_target,
    input  id_valid, id_ir, id_npc,
    output id_ready
  );
endinterface

// File: rtl/if_prefetch_unit.sv
// Instruction-fetch stage: owns the PC, issues word fetches under a credit
// limit, buffers in-order responses in a DEPTH-entry prefetch FIFO and hands
// {IR, NPC} pairs to decode. A redirect flushes queued entries and marks every
// in-flight response for discard.
// Optional build macro: IF_PERF_CNT_EN adds saturating pop/bubble counters.
module if_prefetch_unit #(
  parameter int unsigned   AW       = 32,
  parameter int unsigned   DEPTH    = 4,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               RN,
  if_prefetch_unit_if.master bus
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_bubble_cnt
`endif
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = CW + 1;

  typedef struct packed {
    logic [31:0]   ir;
    logic [AW-1:0] npc;
  } fifo_entry_t;

  logic [AW-1:0] r_pc;
  fifo_entry_t   r_fifo [DEPTH];
  logic [PW-1:0] r_fifo_rd;
  logic [PW-1:0] r_fifo_wr;
  logic [CW-1:0] r_fifo_cnt;
  logic [AW-1:0] r_shadow [DEPTH];
  logic [PW-1:0] r_sh_rd;
  logic [PW-1:0] r_sh_wr;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_discard;

  logic          w_fifo_empty;
  logic          w_credit_ok;
  logic          w_req;
  logic          w_fire;
  logic          w_valid;
  logic          w_pop;
  logic          w_rsp;
  logic          w_drop;
  logic          w_push;
  logic [CW-1:0] w_outstanding_nxt;
  fifo_entry_t   w_push_entry;
  fifo_entry_t   w_head;

  // Issue credit, dequeue qualifiers and response routing
  always_comb begin
    w_fifo_empty      = (r_fifo_cnt == '0);
    w_credit_ok       = (SW'(r_fifo_cnt) + SW'(r_outstanding)) < SW'(DEPTH);
    w_req             = !RN && !bus.br_en && w_credit_ok;
    w_fire            = w_req && bus.imem_ack;
    w_valid           = !w_fifo_empty && !bus.br_en;
    w_pop             = w_valid && bus.id_ready;
    w_rsp             = bus.imem_rvalid;
    w_drop            = w_rsp && (r_discard != '0);
    w_push            = w_rsp && (r_discard == '0) && !bus.br_en;
    w_outstanding_nxt = r_outstanding + CW'(w_fire) - CW'(w_rsp);
    w_push_entry.ir   = bus.imem_rdata;
    w_push_entry.npc  = r_shadow[r_sh_rd] + AW'(1);
    w_head            = w_fifo_empty ? '0 : r_fifo[r_fifo_rd];
  end

  // Program counter: redirect target, else advance on accepted request
  always_ff @(posedge clk) begin
    if (RN) begin
      r_pc <= RESET_PC;
    end else if (bus.br_en) begin
      r_pc <= bus.br_target;
    end else if (w_fire) begin
      r_pc <= r_pc + AW'(1);
    end
  end

  // Outstanding request count; in-flight fetches survive a redirect
  always_ff @(posedge clk) begin
    if (RN) begin
      r_outstanding <= '0;
    end else begin
      r_outstanding <= w_outstanding_nxt;
    end
  end

  // Discard budget: every response still in flight at a redirect is stale
  always_ff @(posedge clk) begin
    if (RN) begin
      r_discard <= '0;
    end else if (bus.br_en) begin
      r_discard <= w_outstanding_nxt;
    end else if (w_drop) begin
      r_discard <= r_discard - CW'(1);
    end
  end

  // Address shadow queue pointers: one entry per outstanding request
  always_ff @(posedge clk) begin
    if (RN) begin
      r_sh_wr <= '0;
      r_sh_rd <= '0;
    end else begin
      if (w_fire) begin
        r_sh_wr <= r_sh_wr + PW'(1);
      end
      if (w_rsp) begin
        r_sh_rd <= r_sh_rd + PW'(1);
      end
    end
  end

  // Address shadow storage, written with the PC of each accepted request
  always_ff @(posedge clk) begin
    if (w_fire) begin
      r_shadow[r_sh_wr] <= r_pc;
    end
  end

  // Prefetch FIFO pointers and occupancy; redirect empties it
  always_ff @(posedge clk) begin
    if (RN) begin
      r_fifo_rd  <= '0;
      r_fifo_wr  <= '0;
      r_fifo_cnt <= '0;
    end else if (bus.br_en) begin
      r_fifo_rd  <= '0;
      r_fifo_wr  <= '0;
      r_fifo_cnt <= '0;
    end else begin
      if (w_push) begin
        r_fifo_wr <= r_fifo_wr + PW'(1);
      end
      if (w_pop) begin
        r_fifo_rd <= r_fifo_rd + PW'(1);
      end
      r_fifo_cnt <= r_fifo_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  // Prefetch FIFO storage
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_fifo_wr] <= w_push_entry;
    end
  end

  assign bus.imem_req  = w_req;
  assign bus.imem_addr = r_pc;
  assign bus.id_valid  = w_valid;
  assign bus.id_ir     = w_head.ir;
  assign bus.id_npc    = w_head.npc;

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_perf_fetch;
  logic [31:0] r_perf_bubble;

  // Saturating counters: delivered instructions and decode-starved cycles
  always_ff @(posedge clk) begin
    if (RN) begin
      r_perf_fetch  <= '0;
      r_perf_bubble <= '0;
    end else begin
      if (w_pop && (r_perf_fetch != '1)) begin
        r_perf_fetch <= r_perf_fetch + 32'd1;
      end
      if (bus.id_ready && !w_valid && (r_perf_bubble != '1)) begin
        r_perf_bubble <= r_perf_bubble + 32'd1;
      end
    end
  end

  assign perf_fetch_cnt  = r_perf_fetch;
  assign perf_bubble_cnt = r_perf_bubble;
`endif

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Bench for if_prefetch_unit: randomized memory/decode environment with a
// queue-based reference model of the fetch stage, plus directed scenarios.
module tb_if_prefetch_unit;
  localparam int unsigned AW      = 8;
  localparam int unsigned DEPTH   = 4;
  localparam logic [31:0] XOR_PAT = 32'hA5A5_0000;

  logic clk;
  logic rn;
  int   n_tests;
  int   n_fail;
  int   cyc;

  if_prefetch_unit_if #(.AW(AW)) bus ();

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_bubble_cnt;
`endif

  if_prefetch_unit #(.AW(AW), .DEPTH(DEPTH), .RESET_PC(8'h00)) dut (
    .clk (clk),
    .RN  (rn),
    .bus (bus)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetch_cnt  (perf_fetch_cnt),
    .perf_bubble_cnt (perf_bubble_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: PC, decode queue, in-flight requests tagged stale/fresh
  logic [AW-1:0] m_pc;
  logic [31:0]   m_fifo_ir [$];
  logic [AW-1:0] m_fifo_npc [$];
  logic [AW-1:0] m_fl_addr [$];
  bit            m_fl_stale [$];
  int            m_pops;
  int            m_bubbles;

  // Memory environment: pending responses with due cycles
  logic [AW-1:0] mem_addr_q [$];
  int            mem_due_q [$];
  int            ack_pct;
  int            rdy_pct;
  int            lat_min;
  int            lat_max;

  // Values sampled mid-cycle by cycle()
  logic          s_rn, s_req, s_valid, s_ack, s_rvalid, s_br, s_rdy;
  logic [AW-1:0] s_addr, s_npc, s_tgt;
  logic [31:0]   s_ir, s_rdata;

  // One clock: sample, score against the model, advance model and memory
  task automatic cycle();
    logic          e_req;
    logic          e_valid;
    logic [AW-1:0] a;
    bit            st;
    int            lat;
    @(negedge clk);
    s_rn = rn; s_req = bus.imem_req; s_addr = bus.imem_addr;
    s_valid = bus.id_valid; s_ir = bus.id_ir; s_npc = bus.id_npc;
    s_ack = bus.imem_ack; s_rvalid = bus.imem_rvalid; s_rdata = bus.imem_rdata;
    s_br = bus.br_en; s_tgt = bus.br_target; s_rdy = bus.id_ready;

    e_req   = !s_rn && !s_br && ((m_fifo_ir.size() + m_fl_addr.size()) < DEPTH);
    e_valid = (m_fifo_ir.size() > 0) && !s_br;
    n_tests++;
    if (s_req !== e_req) begin
      n_fail++; $display("FAIL sb_req cyc=%0d: got %b want %b", cyc, s_req, e_req);
    end
    if (e_req) begin
      n_tests++;
      if (s_addr !== m_pc) begin
        n_fail++; $display("FAIL sb_addr cyc=%0d: got %h want %h", cyc, s_addr, m_pc);
      end
    end
    n_tests++;
    if (s_valid !== e_valid) begin
      n_fail++; $display("FAIL sb_valid cyc=%0d: got %b want %b", cyc, s_valid, e_valid);
    end
    if (e_valid) begin
      n_tests++;
      if (s_ir !== m_fifo_ir[0] || s_npc !== m_fifo_npc[0]) begin
        n_fail++;
        $display("FAIL sb_head cyc=%0d: got ir=%h npc=%h want ir=%h npc=%h",
                 cyc, s_ir, s_npc, m_fifo_ir[0], m_fifo_npc[0]);
      end
    end

    if (s_rn) begin
      m_pc = '0; m_fifo_ir.delete(); m_fifo_npc.delete();
      m_fl_addr.delete(); m_fl_stale.delete(); m_pops = 0; m_bubbles = 0;
    end else begin
      if (e_valid && s_rdy) begin
        void'(m_fifo_ir.pop_front()); void'(m_fifo_npc.pop_front());
        m_pops++;
      end
      if (s_rdy && !e_valid) m_bubbles++;
      if (s_rvalid && m_fl_addr.size() > 0) begin
        a  = m_fl_addr.pop_front();
        st = m_fl_stale.pop_front();
        if (!st && !s_br) begin
          n_tests++;
          if (m_fifo_ir.size() >= DEPTH) begin
            n_fail++; $display("FAIL fifo_overflow cyc=%0d: got size %0d want <%0d", cyc, m_fifo_ir.size(), DEPTH);
          end
          m_fifo_ir.push_back(s_rdata);
          m_fifo_npc.push_back(a + AW'(1));
        end
      end
      if (s_br) begin
        m_fifo_ir.delete(); m_fifo_npc.delete();
        foreach (m_fl_stale[i]) m_fl_stale[i] = 1'b1;
        m_pc = s_tgt;
      end else if (e_req && s_ack) begin
        m_fl_addr.push_back(m_pc); m_fl_stale.push_back(1'b0);
        m_pc = m_pc + AW'(1);
      end
    end

    @(posedge clk);
    cyc++;
    #1;
    if (s_rn) begin
      mem_addr_q.delete(); mem_due_q.delete();
    end else begin
      if (s_rvalid && mem_addr_q.size() > 0) begin
        void'(mem_addr_q.pop_front()); void'(mem_due_q.pop_front());
      end
      if (s_req && s_ack) begin
        lat = int'($urandom_range(lat_max, lat_min));
        mem_addr_q.push_back(s_addr);
        mem_due_q.push_back(cyc + lat - 1);
      end
    end
    bus.imem_rvalid = (mem_due_q.size() > 0) && (mem_due_q[0] <= cyc);
    bus.imem_rdata  = bus.imem_rvalid ? (32'(mem_addr_q[0]) ^ XOR_PAT) : $urandom();
    bus.imem_ack    = int'($urandom_range(99, 0)) < ack_pct;
    bus.id_ready    = int'($urandom_range(99, 0)) < rdy_pct;
  endtask

  task automatic do_reset();
    rn = 1'b1; bus.br_en = 1'b0;
    cycle(); cycle();
    rn = 1'b0;
  endtask

  task automatic test_reset();
    ack_pct = 100; rdy_pct = 100; lat_min = 1; lat_max = 1;
    rn = 1'b1;
    cycle(); cycle();
    n_tests++;
    if (s_req !== 1'b0 || s_valid !== 1'b0 || s_ir !== 32'h0 || s_npc !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got req=%b valid=%b ir=%h npc=%h want 0", s_req, s_valid, s_ir, s_npc);
    end
    rn = 1'b0;
    cycle(); cycle();
    n_tests++;
    if (s_valid !== 1'b0) begin
      n_fail++; $display("FAIL startup_early: got valid=%b want 0", s_valid);
    end
    cycle();
    n_tests++;
    if (s_valid !== 1'b1 || s_ir !== 32'hA5A5_0000 || s_npc !== 8'd1) begin
      n_fail++; $display("FAIL startup_first: got v=%b ir=%h npc=%h want v=1 ir=a5a50000 npc=01", s_valid, s_ir, s_npc);
    end
    for (int k = 2; k <= 5; k++) begin
      cycle();
      n_tests++;
      if (s_valid !== 1'b1 || s_npc !== AW'(k)) begin
        n_fail++; $display("FAIL steady_stream: got v=%b npc=%h want v=1 npc=%h", s_valid, s_npc, AW'(k));
      end
    end
  endtask

  task automatic test_stall();
    int issued;
    ack_pct = 100; rdy_pct = 0; lat_min = 1; lat_max = 1;
    do_reset();
    bus.id_ready = 1'b0;
    issued = 0;
    repeat (10) begin
      cycle();
      if (s_req && s_ack) issued++;
    end
    n_tests++;
    if (issued !== 4 || s_req !== 1'b0) begin
      n_fail++; $display("FAIL stall_credit: got issued=%0d req=%b want 4 and 0", issued, s_req);
    end
    n_tests++;
    if (s_valid !== 1'b1 || s_npc !== 8'd1) begin
      n_fail++; $display("FAIL stall_hold: got v=%b npc=%h want v=1 npc=01", s_valid, s_npc);
    end
    rdy_pct = 100; bus.id_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      cycle();
      n_tests++;
      if (s_valid !== 1'b1 || s_npc !== AW'(k)) begin
        n_fail++; $display("FAIL stall_drain: got v=%b npc=%h want v=1 npc=%h", s_valid, s_npc, AW'(k));
      end
      if (k == 2) begin
        n_tests++;
        if (s_req !== 1'b1 || s_addr !== 8'd4) begin
          n_fail++; $display("FAIL stall_resume: got req=%b addr=%h want 1 04", s_req, s_addr);
        end
      end
    end
  endtask

  task automatic test_redirect();
    int k;
    ack_pct = 100; rdy_pct = 100; lat_min = 3; lat_max = 3;
    do_reset();
    cycle(); cycle();
    bus.br_en = 1'b1; bus.br_target = 8'd25;
    cycle();
    bus.br_en = 1'b0;
    n_tests++;
    if (s_req !== 1'b0 || s_valid !== 1'b0) begin
      n_fail++; $display("FAIL redir_cycle: got req=%b valid=%b want 0 0", s_req, s_valid);
    end
    for (k = 1; k <= 20; k++) begin
      cycle();
      if (k == 1) begin
        n_tests++;
        if (s_req !== 1'b1 || s_addr !== 8'd25) begin
          n_fail++; $display("FAIL redir_addr: got req=%b addr=%h want 1 19", s_req, s_addr);
        end
      end
      if (s_valid) break;
    end
    n_tests++;
    if (k !== 5 || s_npc !== 8'd26) begin
      n_fail++; $display("FAIL redir_latency: got cycle=%0d npc=%h want 5 1a", k, s_npc);
    end
  endtask

  task automatic test_br_rvalid();
    int k;
    ack_pct = 100; rdy_pct = 100; lat_min = 2; lat_max = 2;
    do_reset();
    for (k = 0; k < 20; k++) begin
      cycle();
      if (bus.imem_rvalid && m_fifo_ir.size() > 0) break;
    end
    bus.br_en = 1'b1; bus.br_target = 8'd100; bus.id_ready = 1'b1;
    cycle();
    bus.br_en = 1'b0;
    n_tests++;
    if (s_valid !== 1'b0 || s_req !== 1'b0) begin
      n_fail++; $display("FAIL brrv_nopop: got valid=%b req=%b want 0 0", s_valid, s_req);
    end
    cycle();
    n_tests++;
    if (s_valid !== 1'b0) begin
      n_fail++; $display("FAIL brrv_flushed: got valid=%b want 0", s_valid);
    end
    for (k = 0; k < 20; k++) begin
      cycle();
      if (s_valid) break;
    end
    n_tests++;
    if (s_valid !== 1'b1 || s_npc !== 8'd101 || s_ir !== 32'hA5A5_0064) begin
      n_fail++; $display("FAIL brrv_target: got v=%b npc=%h ir=%h want 1 65 a5a50064", s_valid, s_npc, s_ir);
    end
  endtask

  task automatic test_back_to_back();
    int k;
    ack_pct = 100; rdy_pct = 100; lat_min = 3; lat_max = 3;
    do_reset();
    cycle(); cycle(); cycle();
    bus.br_en = 1'b1; bus.br_target = 8'd40;
    cycle();
    bus.br_target = 8'd60;
    cycle();
    bus.br_en = 1'b0;
    cycle();
    n_tests++;
    if (s_req !== 1'b1 || s_addr !== 8'd60) begin
      n_fail++; $display("FAIL b2b_addr: got req=%b addr=%h want 1 3c", s_req, s_addr);
    end
    for (k = 0; k < 20; k++) begin
      cycle();
      if (s_valid) break;
    end
    n_tests++;
    if (s_valid !== 1'b1 || s_npc !== 8'd61) begin
      n_fail++; $display("FAIL b2b_target: got v=%b npc=%h want 1 3d", s_valid, s_npc);
    end
  endtask

  task automatic test_wrap();
    int k;
    ack_pct = 100; rdy_pct = 100; lat_min = 1; lat_max = 1;
    do_reset();
    cycle(); cycle();
    bus.br_en = 1'b1; bus.br_target = 8'hFF;
    cycle();
    bus.br_en = 1'b0;
    cycle();
    n_tests++;
    if (s_req !== 1'b1 || s_addr !== 8'hFF) begin
      n_fail++; $display("FAIL wrap_ff: got req=%b addr=%h want 1 ff", s_req, s_addr);
    end
    cycle();
    n_tests++;
    if (s_req !== 1'b1 || s_addr !== 8'h00) begin
      n_fail++; $display("FAIL wrap_00: got req=%b addr=%h want 1 00", s_req, s_addr);
    end
    for (k = 0; k < 10; k++) begin
      if (s_valid) break;
      cycle();
    end
    n_tests++;
    if (s_valid !== 1'b1 || s_npc !== 8'h00 || s_ir !== 32'hA5A5_00FF) begin
      n_fail++; $display("FAIL wrap_npc: got v=%b npc=%h ir=%h want 1 00 a5a500ff", s_valid, s_npc, s_ir);
    end
    cycle();
    n_tests++;
    if (s_valid !== 1'b1 || s_npc !== 8'h01) begin
      n_fail++; $display("FAIL wrap_next: got v=%b npc=%h want 1 01", s_valid, s_npc);
    end
  endtask

  task automatic test_random();
    ack_pct = 70; rdy_pct = 60; lat_min = 1; lat_max = 4;
    do_reset();
    repeat (1500) begin
      bus.br_en     = int'($urandom_range(99, 0)) < 4;
      bus.br_target = AW'($urandom());
      cycle();
    end
    bus.br_en = 1'b0;
    repeat (10) cycle();
  endtask

`ifdef IF_PERF_CNT_EN
  task automatic test_perf();
    ack_pct = 80; rdy_pct = 70; lat_min = 1; lat_max = 2;
    do_reset();
    n_tests++;
    if (perf_fetch_cnt !== 32'd0 || perf_bubble_cnt !== 32'd0) begin
      n_fail++; $display("FAIL perf_reset: got fetch=%0d bubble=%0d want 0 0", perf_fetch_cnt, perf_bubble_cnt);
    end
    repeat (20) cycle();
    n_tests++;
    if (perf_fetch_cnt !== 32'(m_pops)) begin
      n_fail++; $display("FAIL perf_fetch: got %0d want %0d", perf_fetch_cnt, m_pops);
    end
    n_tests++;
    if (perf_bubble_cnt !== 32'(m_bubbles)) begin
      n_fail++; $display("FAIL perf_bubble: got %0d want %0d", perf_bubble_cnt, m_bubbles);
    end
    rn = 1'b1;
    cycle();
    rn = 1'b0;
    n_tests++;
    if (perf_fetch_cnt !== 32'd0 || perf_bubble_cnt !== 32'd0) begin
      n_fail++; $display("FAIL perf_clear: got fetch=%0d bubble=%0d want 0 0", perf_fetch_cnt, perf_bubble_cnt);
    end
  endtask
`endif

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0;
    m_pc = '0; m_pops = 0; m_bubbles = 0;
    rn = 1'b1;
    bus.imem_ack = 1'b1; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
    bus.br_en = 1'b0; bus.br_target = '0; bus.id_ready = 1'b1;
    test_reset();
    test_stall();
    test_redirect();
    test_br_rvalid();
    test_back_to_back();
    test_wrap();
    test_random();
`ifdef IF_PERF_CNT_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
